// File: rtl/lzn_pkg.sv
// Shared types and constants for the lz_normalizer leading-zero/one counter.
package lzn_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam logic MODE_CLZ = 1'b0;
  localparam logic MODE_CLO = 1'b1;

  // Binary search starts with half the word and halves each clock.
  function automatic int first_stage(input int width);
    return width / 2;
  endfunction

endpackage

// File: rtl/lz_step.sv
// One binary-search stage: tests whether the top k bits of w all equal the fill bit
// and, if so, shifts them out.
module lz_step #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic [WIDTH-1:0] w,
  input  logic             fill,
  input  logic [CNT_W-1:0] k,
  output logic             hit,
  output logic [WIDTH-1:0] w_shifted,
  output logic [CNT_W-1:0] k_added
);

  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] top_mask;

  // k = 0 disables the stage entirely.
  always_comb begin
    diff      = w ^ {WIDTH{fill}};
    top_mask  = ~({WIDTH{1'b1}} >> k);
    hit       = (k != '0) && ((diff & top_mask) == '0);
    w_shifted = hit ? (w << k) : w;
    k_added   = hit ? k : '0;
  end

endmodule

// File: rtl/lz_normalizer.sv
// Multi-cycle CLZ/CLO with normalized output, one binary-search stage per clock.
// Optional macro LZN_EARLY_DONE_EN lets trivial operands bypass the search.
module lz_normalizer
  import lzn_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] din,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] norm
);

  localparam logic [CNT_W-1:0] K_FIRST = CNT_W'(first_stage(WIDTH));
  localparam logic [CNT_W-1:0] K_LAST  = CNT_W'(1);
`ifdef LZN_EARLY_DONE_EN
  localparam logic [CNT_W-1:0] K_FULL  = CNT_W'(WIDTH);
`endif

  state_e           state_q, state_d;
  logic [WIDTH-1:0] w_q, w_d;
  logic             fill_q, fill_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] k_q, k_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] norm_q, norm_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             s1_hit, s2_hit;
  logic [WIDTH-1:0] s1_w, s2_w;
  logic [CNT_W-1:0] s1_k, s2_k;
  logic [CNT_W-1:0] k2;
  logic             unused_hits;

  // The second stage is the final one-bit check, live only on the k=1 clock.
  assign k2 = (state_q == SEARCH && k_q == K_LAST) ? K_LAST : '0;
  assign unused_hits = s1_hit | s2_hit;

  lz_step #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_step (
    .w(w_q), .fill(fill_q), .k(k_q),
    .hit(s1_hit), .w_shifted(s1_w), .k_added(s1_k)
  );

  lz_step #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_final (
    .w(s1_w), .fill(fill_q), .k(k2),
    .hit(s2_hit), .w_shifted(s2_w), .k_added(s2_k)
  );

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    fill_d  = fill_q;
    acc_d   = acc_q;
    k_d     = k_q;
    count_d = count_q;
    norm_d  = norm_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      SEARCH: begin
        acc_d = acc_q + s1_k + s2_k;
        w_d   = s2_w;
        k_d   = k_q >> 1;
        if (k_q == K_LAST) begin
          count_d = acc_d;
          norm_d  = w_d;
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          busy_d  = 1'b1;
        end
      end
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          w_d     = din;
          fill_d  = mode;
          acc_d   = '0;
          k_d     = K_FIRST;
          state_d = SEARCH;
          busy_d  = 1'b1;
`ifdef LZN_EARLY_DONE_EN
          if (din[WIDTH-1] != mode) begin
            count_d = '0;
            norm_d  = din;
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else if (din == {WIDTH{mode}}) begin
            count_d = K_FULL;
            norm_d  = '0;
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      w_q     <= '0;
      fill_q  <= 1'b0;
      acc_q   <= '0;
      k_q     <= '0;
      count_q <= '0;
      norm_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      fill_q  <= fill_d;
      acc_q   <= acc_d;
      k_q     <= k_d;
      count_q <= count_d;
      norm_q  <= norm_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign count = count_q;
  assign norm  = norm_q;

endmodule
